// File: rtl/bit_scan_iter_pkg.sv
// Shared helpers for the set-bit enumerator and its priority encoder.
// Index width is derived here so the top and the encoder always agree.
package bit_scan_iter_pkg;

  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/bit_scan_iter_prio_enc.sv
// Parameterised priority encoder: selects the lowest (or highest) set bit.
// Also returns the one-hot of that bit so callers can clear it cheaply.
module bit_prio_enc
  import bit_scan_iter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MSB_FIRST = 0,
  localparam int IDX_W    = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o,
  output logic [WIDTH-1:0] onehot_o
);

  // The last match in the loop wins, so scan direction picks lowest vs highest.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST != 0) begin
        if (vec_i[i]) idx_o = IDX_W'(i);
      end else begin
        if (vec_i[WIDTH-1-i]) idx_o = IDX_W'(WIDTH-1-i);
      end
    end
  end

  assign any_o    = |vec_i;
  assign onehot_o = any_o ? (WIDTH'(1) << idx_o) : '0;

endmodule

// File: rtl/bit_scan_iter.sv
// Set-bit enumerator: accepts a word and emits one beat per set bit.
// All beat fields come from registers; no in_* to out_* combinational path.
module bit_scan_iter
  import bit_scan_iter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MSB_FIRST = 0,
  localparam int IDX_W    = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_ord,
  output logic             out_last,
  output logic             out_none
);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [IDX_W:0]   ord_q, ord_d;
  logic             none_q, none_d;

  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic [WIDTH-1:0] sel_onehot;
  logic             accept, beat;

  bit_prio_enc #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_enc (
    .vec_i    (rem_q),
    .idx_o    (sel_idx),
    .any_o    (sel_any),
    .onehot_o (sel_onehot)
  );

  assign out_valid = (state_q == SCAN);
  assign out_idx   = sel_idx;
  assign out_ord   = ord_q;
  assign out_none  = none_q;
  // At most one bit set: nothing left once the selected bit is removed.
  assign out_last  = !sel_any || ((rem_q & ~sel_onehot) == '0);

  assign beat     = out_valid && out_ready;
  assign in_ready = !flush && ((state_q == IDLE) || (beat && out_last));
  assign accept   = in_valid && in_ready;

  // A new word in the last-beat cycle overrides the beat's clear and IDLE step.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ord_d   = ord_q;
    none_d  = none_q;
    if (flush) begin
      state_d = IDLE;
      rem_d   = '0;
      ord_d   = '0;
      none_d  = 1'b0;
    end else begin
      if (beat) begin
        rem_d = rem_q & ~sel_onehot;
        ord_d = ord_q + 1'b1;
        if (out_last) state_d = IDLE;
      end
      if (accept) begin
        state_d = SCAN;
        rem_d   = in_data;
        ord_d   = '0;
        none_d  = (in_data == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ord_q   <= '0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ord_q   <= ord_d;
      none_q  <= none_d;
    end
  end

endmodule

// File: tb/tb_bit_scan_iter.sv
// Randomised bench for bit_scan_iter: ascending and descending instances share
// stimulus and are checked against a queue-of-beats reference model.
module tb_bit_scan_iter;

  typedef struct {
    int idx;
    int ord;
    bit last;
    bit none;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic       inReadyA, outValidA, outLastA, outNoneA;
  logic [4:0] outIdxA;
  logic [5:0] outOrdA;
  logic       inReadyD, outValidD, outLastD, outNoneD;
  logic [4:0] outIdxD;
  logic [5:0] outOrdD;

  int vecCount = 0;
  int errCount = 0;

  beat_t expAsc[$];
  beat_t expDesc[$];

  always #5 clk = ~clk;

  bit_scan_iter #(.WIDTH(32), .MSB_FIRST(0)) dutAsc (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(inReadyA), .in_data(in_data),
    .out_valid(outValidA), .out_ready(out_ready),
    .out_idx(outIdxA), .out_ord(outOrdA), .out_last(outLastA), .out_none(outNoneA)
  );

  bit_scan_iter #(.WIDTH(32), .MSB_FIRST(1)) dutDesc (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(inReadyD), .in_data(in_data),
    .out_valid(outValidD), .out_ready(out_ready),
    .out_idx(outIdxD), .out_ord(outOrdD), .out_last(outLastD), .out_none(outNoneD)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Expected beats straight from the rule: every set bit, in bit order.
  function automatic void pushWord(input logic [31:0] d);
    int pos[$];
    int n;
    if (d == 0) begin
      expAsc.push_back('{0, 0, 1'b1, 1'b1});
      expDesc.push_back('{0, 0, 1'b1, 1'b1});
      return;
    end
    for (int b = 0; b < 32; b++)
      if (d[b]) pos.push_back(b);
    n = pos.size();
    for (int k = 0; k < n; k++) begin
      expAsc.push_back('{pos[k], k, (k == n - 1), 1'b0});
      expDesc.push_back('{pos[n - 1 - k], k, (k == n - 1), 1'b0});
    end
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rdyA"}, inReadyA, 1);
    checkOutput({tag, "_rdyD"}, inReadyD, 1);
    checkOutput({tag, "_vldA"}, outValidA, 0);
    checkOutput({tag, "_vldD"}, outValidD, 0);
    checkOutput({tag, "_idxA"}, outIdxA, 0);
    checkOutput({tag, "_ordA"}, outOrdA, 0);
    checkOutput({tag, "_lastA"}, outLastA, 1);
    checkOutput({tag, "_noneA"}, outNoneA, 0);
    checkOutput({tag, "_idxD"}, outIdxD, 0);
    checkOutput({tag, "_ordD"}, outOrdD, 0);
    checkOutput({tag, "_lastD"}, outLastD, 1);
    checkOutput({tag, "_noneD"}, outNoneD, 0);
  endtask

  // One cycle: drive inputs on the falling edge, check, then advance the model.
  task automatic applyStimulus(input bit fl, input bit v, input logic [31:0] d, input bit r);
    bit expRdy;
    bit busy;
    @(negedge clk);
    flush = fl;
    in_valid = v;
    in_data = d;
    out_ready = r;
    #1;
    busy = (expAsc.size() != 0);
    expRdy = !fl && (!busy || (r && expAsc.size() == 1));
    checkOutput("in_readyA", inReadyA, expRdy);
    checkOutput("in_readyD", inReadyD, expRdy);
    checkOutput("out_validA", outValidA, busy);
    checkOutput("out_validD", outValidD, busy);
    if (busy) begin
      checkOutput("idxA", outIdxA, expAsc[0].idx);
      checkOutput("ordA", outOrdA, expAsc[0].ord);
      checkOutput("lastA", outLastA, expAsc[0].last);
      checkOutput("noneA", outNoneA, expAsc[0].none);
      checkOutput("idxD", outIdxD, expDesc[0].idx);
      checkOutput("ordD", outOrdD, expDesc[0].ord);
      checkOutput("lastD", outLastD, expDesc[0].last);
      checkOutput("noneD", outNoneD, expDesc[0].none);
    end
    if (fl) begin
      expAsc.delete();
      expDesc.delete();
    end else begin
      if (r && busy) begin
        void'(expAsc.pop_front());
        void'(expDesc.pop_front());
      end
      if (v && expRdy) pushWord(d);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (expAsc.size() != 0 && guard < 100) begin
      applyStimulus(0, 0, 32'h0, 1);
      guard++;
    end
    checkOutput("drain_timeout", expAsc.size(), 0);
  endtask

  function automatic logic [31:0] randomWord();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'h1 << $urandom_range(0, 31);
      2:       return $urandom();
      default: return $urandom() & $urandom() & $urandom();
    endcase
  endfunction

  initial begin
    #1;
    checkResetValues("reset");
    #12 reset_n = 1'b1;

    applyStimulus(0, 1, 32'h8000_0005, 1);
    drain();
    applyStimulus(0, 0, 32'h0, 1);

    applyStimulus(0, 1, 32'h0000_0000, 1);
    drain();
    applyStimulus(0, 0, 32'h0, 1);

    applyStimulus(0, 1, 32'hFFFF_FFFF, 1);
    for (int c = 0; c < 200 && expAsc.size() != 0; c++)
      applyStimulus(0, 0, 32'h0, 1'($urandom_range(0, 1)));
    drain();

    applyStimulus(0, 1, 32'h0000_0001, 1);
    applyStimulus(0, 1, 32'h0000_0002, 1);
    applyStimulus(0, 1, 32'h0000_0002, 1);
    applyStimulus(0, 0, 32'h0, 1);
    drain();

    applyStimulus(0, 1, 32'h0000_00F0, 1);
    applyStimulus(0, 0, 32'h0, 1);
    applyStimulus(0, 0, 32'h0, 1);
    applyStimulus(1, 1, 32'h0000_0003, 1);
    applyStimulus(0, 0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 1);

    applyStimulus(0, 1, 32'h0000_00F0, 1);
    applyStimulus(0, 0, 32'h0, 1);
    applyStimulus(0, 0, 32'h0, 0);
    #1;
    reset_n = 1'b0;
    #1;
    expAsc.delete();
    expDesc.delete();
    checkResetValues("midreset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int c = 0; c < 600; c++)
      applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6),
                    randomWord(), ($urandom_range(0, 9) < 7));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
